// File: rtl/button_conditioner.sv
// Five-button input conditioner: two-flop synchronizer, debounce FSM and
// registered one-cycle press pulse per button, plus debounced levels.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat on L/R/U/D while held).
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       BtnL_raw,
    input  logic       BtnR_raw,
    input  logic       BtnU_raw,
    input  logic       BtnD_raw,
    input  logic       BtnC_raw,
    output logic       BtnL,
    output logic       BtnR,
    output logic       BtnU,
    output logic       BtnD,
    output logic       BtnC,
    output logic [4:0] Held
);

    typedef enum logic [2:0] {
        WAIT_RELEASE,
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [19:0] DB_LIMIT  = 20'(DEBOUNCE_CYCLES);
    localparam logic [19:0] COUNT_MAX = 20'hFFFFF;

    // Reject parameter values outside the 20-bit counter range at elaboration
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..2^20-1");
    end
    if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 1048575) begin : g_bad_repeat
        $error("REPEAT_CYCLES out of range 1..2^20-1");
    end

    logic [4:0] raw;
    logic [4:0] sync_meta;
    logic [4:0] sync_out;
    logic [4:0] pulse;
    logic [4:0] level;

    assign raw = {BtnL_raw, BtnR_raw, BtnU_raw, BtnD_raw, BtnC_raw};

    // Two-flop synchronizer bringing the asynchronous buttons into the clock domain
    always_ff @(posedge Clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_btn
        state_t      state;
        state_t      state_next;
        logic [19:0] count;
        logic [19:0] count_next;
        logic [19:0] count_inc;
        logic        pulse_q;
        logic        pulse_next;
        logic        s;

        assign s         = sync_out[i];
        assign count_inc = (count == COUNT_MAX) ? count : count + 20'd1;

`ifdef BTN_AUTO_REPEAT_EN
        // The centre button (bit 0) never auto-repeats
        localparam bit REPEAT_ON = (i != 0);
        localparam logic [19:0] REPEAT_LAST = 20'(REPEAT_CYCLES - 1);
        logic [19:0] rep;
        logic [19:0] rep_next;
        logic [19:0] rep_inc;

        assign rep_inc = (rep == COUNT_MAX) ? rep : rep + 20'd1;
`endif

        // State, debounce counter and registered pulse for this button
        always_ff @(posedge Clk) begin
            if (reset) begin
                state   <= WAIT_RELEASE;
                count   <= '0;
                pulse_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                rep     <= '0;
`endif
            end else begin
                state   <= state_next;
                count   <= count_next;
                pulse_q <= pulse_next;
`ifdef BTN_AUTO_REPEAT_EN
                rep     <= rep_next;
`endif
            end
        end

        // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples
        always_comb begin
            state_next = state;
            count_next = count;
            pulse_next = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_next   = rep;
`endif
            case (state)
                WAIT_RELEASE: begin
                    if (count >= DB_LIMIT) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else if (!s) begin
                        count_next = count_inc;
                    end else begin
                        count_next = '0;
                    end
                end
                IDLE: begin
                    if (s) begin
                        state_next = PRESS_DB;
                        count_next = 20'd1;
                    end
                end
                PRESS_DB: begin
                    if (count >= DB_LIMIT) begin
                        state_next = HELD;
                        count_next = '0;
                        pulse_next = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_next   = '0;
`endif
                    end else if (s) begin
                        count_next = count_inc;
                    end else begin
                        state_next = IDLE;
                        count_next = '0;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_next = RELEASE_DB;
                        count_next = 20'd1;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (REPEAT_ON) begin
                        if (rep >= REPEAT_LAST) begin
                            pulse_next = 1'b1;
                            rep_next   = '0;
                        end else begin
                            rep_next = rep_inc;
                        end
                    end
`endif
                end
                RELEASE_DB: begin
                    if (count >= DB_LIMIT) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else if (!s) begin
                        count_next = count_inc;
                    end else begin
                        state_next = HELD;
                        count_next = '0;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_next   = '0;
`endif
                    end
                end
                default: begin
                    state_next = WAIT_RELEASE;
                    count_next = '0;
                end
            endcase
        end

        assign pulse[i] = pulse_q;
        assign level[i] = (state == HELD) || (state == RELEASE_DB);
    end

    assign {BtnL, BtnR, BtnU, BtnD, BtnC} = pulse;
    assign Held = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus pushes the expected pulse
// cycle per button, a negedge monitor pops and compares every observed pulse.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RP = 16;

    logic       Clk = 1'b0;
    logic       reset;
    logic       BtnL_raw, BtnR_raw, BtnU_raw, BtnD_raw, BtnC_raw;
    logic       BtnL, BtnR, BtnU, BtnD, BtnC;
    logic [4:0] Held;
    logic [4:0] pulses;
    logic [4:0] raw_vec;

    typedef struct {
        int btn;
        int cycle;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES(RP)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .BtnL_raw(BtnL_raw),
        .BtnR_raw(BtnR_raw),
        .BtnU_raw(BtnU_raw),
        .BtnD_raw(BtnD_raw),
        .BtnC_raw(BtnC_raw),
        .BtnL(BtnL),
        .BtnR(BtnR),
        .BtnU(BtnU),
        .BtnD(BtnD),
        .BtnC(BtnC),
        .Held(Held)
    );

    assign pulses = {BtnL, BtnR, BtnU, BtnD, BtnC};

    // 20 ns clock
    always #10 Clk = ~Clk;

    // Posedge counter used as the time base for expected pulse cycles
    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every pulse seen must match the oldest expectation for that button
    always @(negedge Clk) begin
        int idx;
        for (int b = 0; b < 5; b++) begin
            if (pulses[b]) begin
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (idx < 0 && sb[j].btn == b) idx = j;
                end
                tests_run++;
                if (idx < 0) begin
                    tests_failed++;
                    $display("[TB] FAIL unexpected_pulse btn%0d: pulse at cycle %0d, required none", b, cyc);
                end else begin
                    if (sb[idx].cycle != cyc) begin
                        tests_failed++;
                        $display("[TB] FAIL pulse_cycle btn%0d: got cycle %0d, required %0d", b, cyc, sb[idx].cycle);
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] v);
        {BtnL_raw, BtnR_raw, BtnU_raw, BtnD_raw, BtnC_raw} = v;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %b, required %b", name, cyc, actual, expected);
        end
    endtask

    // Push an expected pulse: raw rose at this negedge, so the pulse appears DB+3 posedges later
    task automatic expectPulse(input int btn, input int extra);
        exp_t e;
        e.btn   = btn;
        e.cycle = cyc + DB + 3 + extra;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Hold the current raw pattern n cycles, checking Held from cycle 8 on
    task automatic holdAndCheck(input string name, input int n, input logic [4:0] held_exp);
        for (int k = 1; k <= n; k++) begin
            @(negedge Clk);
            if (k >= DB + 4) checkOutput(name, Held, held_exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        raw_vec = 5'b0;
        applyStimulus(raw_vec);

        // Reset state and first edge after release
        idle(3);
        checkOutput("reset_held", Held, 5'b0);
        checkOutput("reset_pulse", pulses, 5'b0);
        reset = 1'b0;
        @(negedge Clk);
        checkOutput("post_reset_held", Held, 5'b0);
        checkOutput("post_reset_pulse", pulses, 5'b0);
        idle(10);

        // Clean press on C
        raw_vec = 5'b00001;
        applyStimulus(raw_vec);
        expectPulse(0, 0);
        holdAndCheck("clean_held", 10, 5'b00001);
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        idle(12);
        checkOutput("clean_release", Held, 5'b0);

        // Bounce on R shorter than the debounce window
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            raw_vec = (k % 2 == 0) ? 5'b01000 : 5'b00000;
            applyStimulus(raw_vec);
        end
        @(negedge Clk);
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            checkOutput("bounce_held", Held, 5'b0);
        end

        // Simultaneous L and D
        raw_vec = 5'b10010;
        applyStimulus(raw_vec);
        expectPulse(4, 0);
        expectPulse(1, 0);
        holdAndCheck("simul_held", 10, 5'b10010);
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        idle(12);
        checkOutput("simul_release", Held, 5'b0);

        // Release glitch on C: two low cycles must not re-pulse or drop Held
        raw_vec = 5'b00001;
        applyStimulus(raw_vec);
        expectPulse(0, 0);
        idle(12);
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            checkOutput("glitch_held", Held, 5'b00001);
        end
        raw_vec = 5'b00001;
        applyStimulus(raw_vec);
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            checkOutput("glitch_held", Held, 5'b00001);
        end
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        idle(12);

        // U held across reset, reset landing mid-debounce
        raw_vec = 5'b00100;
        applyStimulus(raw_vec);
        idle(5);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            checkOutput("reset_mid_held", Held, 5'b0);
            checkOutput("reset_mid_pulse", pulses, 5'b0);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            checkOutput("held_over_reset", Held, 5'b0);
        end
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        idle(5);
        raw_vec = 5'b00100;
        applyStimulus(raw_vec);
        expectPulse(2, 0);
        holdAndCheck("repress_held", 10, 5'b00100);
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        idle(12);

        // Long hold on R then on C
        raw_vec = 5'b01000;
        applyStimulus(raw_vec);
        expectPulse(3, 0);
`ifdef BTN_AUTO_REPEAT_EN
        expectPulse(3, RP);
        expectPulse(3, 2 * RP);
`endif
        holdAndCheck("long_r_held", 50, 5'b01000);
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        idle(12);
        raw_vec = 5'b00001;
        applyStimulus(raw_vec);
        expectPulse(0, 0);
        holdAndCheck("long_c_held", 50, 5'b00001);
        raw_vec = 5'b0;
        applyStimulus(raw_vec);
        idle(20);
        checkOutput("final_held", Held, 5'b0);

        // Any expectation left over is a pulse that never came
        while (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL missing_pulse btn%0d: got none, required pulse at cycle %0d", sb[0].btn, sb[0].cycle);
            sb.delete(0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
